seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
Run controller for a programmable serial bit-pattern detector. It generalises the fixed 1100 Mealy detector to a pattern of 1..MAX_LEN bits with selectable overlap or non-overlap matching. Software programs the pattern, length, mode and target count while idle, then starts a run. The block counts matches and stops (DONE) when the target is reached. It sits between the control/register interface and the serial input stream.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of the match counter and target

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe; accepted only in IDLE
cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last
cfg_len  in  $clog2(MAX_LEN+1)  pattern length; legal range 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping
cfg_target  in  CNT_W  match count that ends the run; 0 = unlimited
start  in  1  begin a run (from IDLE or DONE)
abort  in  1  end a run immediately
din  in  1  serial data bit
din_valid  in  1  din is qualified this cycle
match  out  1  one-cycle pulse per detected match
match_cnt  out  CNT_W  matches counted in the current or last run
busy  out  1  high in RUN
done  out  1  high in DONE
cfg_err  out  1  one-cycle pulse on a rejected config write

Behaviour:
- Reset: state IDLE. All outputs 0. History and fill count cleared. Config registers reset to pattern 0, len 1, overlap 0, target 0.
- Outputs match, match_cnt, busy, done and cfg_err are registered.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE when the match count reaches a non-zero target.
  - RUN -> IDLE on abort.
  - DONE -> RUN on start; DONE -> IDLE on abort.
  - If abort and start are both high in the same cycle, abort wins.
- Entering RUN clears match_cnt, the history register and the fill count.
- Config writes:
  - A write in IDLE with legal cfg_len updates all config registers; they take effect on the next start.
  - cfg_len = 0, cfg_len > MAX_LEN, or any cfg_we outside IDLE: config is unchanged and cfg_err pulses the following cycle.
- RUN data path:
  - On din_valid, shift din into the LSB of the history register and increment the fill count, saturating at MAX_LEN.
  - A completing bit is one where fill >= cfg_len (after the shift) and history[cfg_len-1:0] == cfg_pattern[cfg_len-1:0].
  - Cycles with din_valid low do not shift and cannot match.
- Match response: match pulses high in the cycle after the completing bit's din_valid (latency 1), and match_cnt increments in that same cycle.
- Overlap mode:
  - cfg_overlap = 1: history and fill are kept after a match, so overlapping matches are found.
  - cfg_overlap = 0: fill is reset to 0 on a match, so the next match needs cfg_len fresh bits.
- Target handling:
  - With a non-zero target, the transition to DONE happens in the same cycle as the match pulse that brings match_cnt up to cfg_target.
  - With target 0, match_cnt saturates at all-ones and the run never finishes by itself.
- In IDLE and DONE: din is ignored, match_cnt holds its last value, match stays 0.
- Abort: match_cnt is retained. A match completing in the same cycle as abort is discarded.
- rst mid-run behaves exactly like power-on reset.

Decomposition:
- Package seq_det_pkg: state enum (IDLE, RUN, DONE), MAX_LEN default, width function for cfg_len.
- Sub-module seq_det_core: history shift register, fill counter, masked compare, overlap/non-overlap fill reset. Inputs: din, din_valid, clear, cfg. Output: a registered hit pulse.
- seq_det_ctrl holds the FSM, config registers and error check, match counter, and target compare.

Test Plan:
- len=4, pattern=4'b1100, overlap=0, target=0; stream 1,1,0,0,1,1,0,0 -> match after the 4th and 8th valid bits; match_cnt=2; busy=1 throughout.
- len=3, pattern=3'b101, stream 1,0,1,0,1 -> overlap=1 gives matches after bits 3 and 5 (cnt=2); overlap=0 gives a match after bit 3 only (cnt=1).
- target=3, pattern 1100 repeated 4 times -> done=1 and busy=0 in the cycle of the 3rd match; the 4th occurrence gives no match; match_cnt stays 3; start then gives RUN with match_cnt=0.
- cfg_we with cfg_len=0 in IDLE, and cfg_we with a legal value in RUN -> each gives a one-cycle cfg_err and the config is unchanged (the next run still detects the old pattern).
- Stream 1100 with din_valid low for 3 cycles between the 2nd and 3rd bits -> exactly one match, 1 cycle after the final valid bit.
- start and abort both high in RUN -> IDLE, busy=0. Separately, rst asserted mid-run -> all outputs 0 the next cycle and the config restored to reset values.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    // Width needed to hold a pattern length of 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_if.sv
// Control/config and serial-stream bundle between software side and detector.
// Latency: n/a (wires only).
// Backpressure: none; din is qualified by din_valid, no ready path.
// master: drives config, start/abort and the serial stream; observes status.
// slave : the detector; receives the above and drives match/count/status.
interface seq_det_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               abort;
    logic               din;
    logic               din_valid;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;
    logic               cfg_err;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output start, abort, din, din_valid,
        input  match, match_cnt, busy, done, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  start, abort, din, din_valid,
        output match, match_cnt, busy, done, cfg_err
    );

endinterface

// File: rtl/seq_det_core.sv
// Shift-register pattern matcher: history, fill count, masked compare.
// Latency: hit is registered, 1 cycle after the completing valid bit.
// Backpressure: none; every din_valid bit is consumed while en is high.
// Ports: clk/rst, clear (restart history), en (run window), kill (drop a
// hit this cycle), din/din_valid, cfg_* (pattern, length, overlap),
// hit_nxt (combinational hit for the controller), hit (registered pulse).
module seq_det_core
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LW      = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               en,
    input  logic               kill,
    input  logic               din,
    input  logic               din_valid,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    output logic               hit_nxt,
    output logic               hit
);

    logic [MAX_LEN-1:0] hist_q, hist_d, hist_sh, mask;
    logic [LW-1:0]      fill_q, fill_d, fill_inc;
    logic               hit_q, hit_d;
    logic               cmp_hit;

    always_comb begin
        hist_sh  = {hist_q[MAX_LEN-2:0], din};
        fill_inc = (fill_q >= LW'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(cfg_len));
        end
        // Compare only the low cfg_len bits, and only once enough bits
        // have arrived since the last clear / non-overlapping match.
        cmp_hit = ((hist_sh & mask) == (cfg_pattern & mask)) && (fill_inc >= cfg_len);
        hit_nxt = en && din_valid && cmp_hit && !kill;

        hist_d = hist_q;
        fill_d = fill_q;
        hit_d  = hit_nxt;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
            hit_d  = 1'b0;
        end else if (en && din_valid) begin
            hist_d = hist_sh;
            // Non-overlap: forget the matched bits so the next match needs
            // a full fresh pattern.
            fill_d = (cmp_hit && !cfg_overlap) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            hit_q  <= hit_d;
        end
    end

    assign hit = hit_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller: config regs, IDLE/RUN/DONE FSM, match counter, target stop.
// Latency: all outputs registered; match/count/DONE 1 cycle after the bit.
// Backpressure: none; config writes outside IDLE are rejected with cfg_err.
// Ports: clk, rst (sync, active-high), bus (seq_det_if.slave) carrying
// config, start/abort, serial din/din_valid and match/count/status.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic   clk,
    input  logic   rst,
    seq_det_if.slave bus
);

    localparam int LW = len_w(MAX_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               cfg_ok, start_ok, tgt_hit;
    logic               hit_nxt, hit;

    seq_det_core #(
        .MAX_LEN (MAX_LEN),
        .LW      (LW)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_ok),
        .en          (state_q == ST_RUN),
        .kill        (bus.abort),
        .din         (bus.din),
        .din_valid   (bus.din_valid),
        .cfg_pattern (pat_q),
        .cfg_len     (len_q),
        .cfg_overlap (ovl_q),
        .hit_nxt     (hit_nxt),
        .hit         (hit)
    );

    always_comb begin
        cfg_ok   = bus.cfg_we && (state_q == ST_IDLE) &&
                   (bus.cfg_len != '0) && (bus.cfg_len <= LW'(MAX_LEN));
        // abort has priority over start; start is only meaningful outside RUN.
        start_ok = bus.start && !bus.abort && (state_q != ST_RUN);
        // Target 0 means unlimited, so the counter saturates instead of wrapping.
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        tgt_hit  = hit_nxt && (tgt_q != '0) && (cnt_inc == tgt_q);

        pat_d = pat_q;
        len_d = len_q;
        ovl_d = ovl_q;
        tgt_d = tgt_q;
        if (cfg_ok) begin
            pat_d = bus.cfg_pattern;
            len_d = bus.cfg_len;
            ovl_d = bus.cfg_overlap;
            tgt_d = bus.cfg_target;
        end
        err_d = bus.cfg_we && !cfg_ok;

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_RUN;
            ST_RUN: begin
                if (bus.abort)    state_d = ST_IDLE;
                else if (tgt_hit) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.abort)    state_d = ST_IDLE;
                else if (start_ok) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase

        cnt_d = cnt_q;
        if (start_ok)     cnt_d = '0;
        else if (hit_nxt) cnt_d = cnt_inc;

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= LW'(1);
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.match     = hit;
    assign bus.match_cnt = cnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: vector table plus hand-written sequences.
// Latency: each vector is applied for one cycle, outputs checked after the edge.
// Backpressure: n/a.
module tb_seq_det_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_det_if #(.MAX_LEN(8), .CNT_W(8)) bus ();

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       we;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic [7:0] tgt;
        logic       st;
        logic       ab;
        logic       d;
        logic       dv;
        logic       em;
        logic [7:0] ec;
        logic       eb;
        logic       ed;
        logic       ee;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic we, input logic [7:0] pat,
                       input logic [3:0] len, input logic ov, input logic [7:0] tgt,
                       input logic st, input logic ab, input logic d, input logic dv,
                       input logic em, input logic [7:0] ec, input logic eb,
                       input logic ed, input logic ee);
        vec_t v;
        v.r = r; v.we = we; v.pat = pat; v.len = len; v.ov = ov; v.tgt = tgt;
        v.st = st; v.ab = ab; v.d = d; v.dv = dv;
        v.em = em; v.ec = ec; v.eb = eb; v.ed = ed; v.ee = ee;
        vq.push_back(v);
    endtask

    task automatic ctl(input logic r, input logic st, input logic ab,
                       input logic [7:0] ec, input logic eb, input logic ed);
        add(r, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00, st, ab, 1'b0, 1'b0, 1'b0, ec, eb, ed, 1'b0);
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                       input logic [7:0] tgt, input logic ee, input logic [7:0] ec,
                       input logic eb);
        add(1'b0, 1'b1, pat, len, ov, tgt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ec, eb, 1'b0, ee);
    endtask

    task automatic bt(input logic d, input logic dv, input logic em,
                      input logic [7:0] ec, input logic eb, input logic ed);
        add(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, d, dv, em, ec, eb, ed, 1'b0);
    endtask

    task automatic drive(input vec_t v);
        rst             = v.r;
        bus.cfg_we      = v.we;
        bus.cfg_pattern = v.pat;
        bus.cfg_len     = v.len;
        bus.cfg_overlap = v.ov;
        bus.cfg_target  = v.tgt;
        bus.start       = v.st;
        bus.abort       = v.ab;
        bus.din         = v.d;
        bus.din_valid   = v.dv;
    endtask

    task automatic apply(input vec_t v, input string nm, input logic do_chk);
        logic [11:0] act, exp_v;
        drive(v);
        @(posedge clk);
        #1;
        if (do_chk) begin
            act   = {bus.match, bus.match_cnt, bus.busy, bus.done, bus.cfg_err};
            exp_v = {v.em, v.ec, v.eb, v.ed, v.ee};
            n_cmp++;
            if (act !== exp_v) begin
                n_bad++;
                $display("FAIL %s: got {match,cnt,busy,done,err}=%b_%h_%b%b%b want %b_%h_%b%b%b",
                         nm, act[11], act[10:3], act[2], act[1], act[0],
                         exp_v[11], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    initial begin
        vec_t h;
        bus.cfg_we = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_overlap = 0;
        bus.cfg_target = 0; bus.start = 0; bus.abort = 0; bus.din = 0; bus.din_valid = 0;

        // Reset, then 1100 non-overlap, unlimited target.
        ctl(1, 0, 0, 0, 0, 0);
        cfg(8'h0C, 4'd4, 0, 8'd0, 0, 0, 0);
        ctl(0, 1, 0, 0, 1, 0);
        bt(1, 1, 0, 0, 1, 0); bt(1, 1, 0, 0, 1, 0); bt(0, 1, 0, 0, 1, 0); bt(0, 1, 1, 1, 1, 0);
        bt(1, 1, 0, 1, 1, 0); bt(1, 1, 0, 1, 1, 0); bt(0, 1, 0, 1, 1, 0); bt(0, 1, 1, 2, 1, 0);
        ctl(0, 0, 1, 2, 0, 0);

        // 101 overlapping: hits on bits 3 and 5.
        cfg(8'h05, 4'd3, 1, 8'd0, 0, 2, 0);
        ctl(0, 1, 0, 0, 1, 0);
        bt(1, 1, 0, 0, 1, 0); bt(0, 1, 0, 0, 1, 0); bt(1, 1, 1, 1, 1, 0);
        bt(0, 1, 0, 1, 1, 0); bt(1, 1, 1, 2, 1, 0);
        ctl(0, 0, 1, 2, 0, 0);

        // 101 non-overlapping: only bit 3.
        cfg(8'h05, 4'd3, 0, 8'd0, 0, 2, 0);
        ctl(0, 1, 0, 0, 1, 0);
        bt(1, 1, 0, 0, 1, 0); bt(0, 1, 0, 0, 1, 0); bt(1, 1, 1, 1, 1, 0);
        bt(0, 1, 0, 1, 1, 0); bt(1, 1, 0, 1, 1, 0);
        ctl(0, 0, 1, 1, 0, 0);

        // Target 3 over four 1100 repeats; DONE on the third match.
        cfg(8'h0C, 4'd4, 0, 8'd3, 0, 1, 0);
        ctl(0, 1, 0, 0, 1, 0);
        for (int k = 1; k <= 16; k++) begin
            bt(((k - 1) % 4) < 2, 1, (k % 4 == 0) && (k <= 12),
               8'((k >= 12) ? 3 : k / 4), k < 12, k >= 12);
        end
        ctl(0, 1, 0, 0, 1, 0);
        ctl(0, 0, 1, 0, 0, 0);

        // Rejected config writes: len 0, len > MAX_LEN, any write in RUN.
        cfg(8'hFF, 4'd0, 1, 8'd0, 1, 0, 0);
        ctl(0, 0, 0, 0, 0, 0);
        cfg(8'hFF, 4'd9, 1, 8'd0, 1, 0, 0);
        ctl(0, 1, 0, 0, 1, 0);
        cfg(8'h03, 4'd2, 1, 8'd0, 1, 0, 1);
        bt(1, 1, 0, 0, 1, 0); bt(1, 1, 0, 0, 1, 0); bt(0, 1, 0, 0, 1, 0); bt(0, 1, 1, 1, 1, 0);
        ctl(0, 0, 1, 1, 0, 0);

        // din_valid gap of 3 cycles between the 2nd and 3rd bits.
        ctl(0, 1, 0, 0, 1, 0);
        bt(1, 1, 0, 0, 1, 0); bt(1, 1, 0, 0, 1, 0);
        bt(0, 0, 0, 0, 1, 0); bt(0, 0, 0, 0, 1, 0); bt(0, 0, 0, 0, 1, 0);
        bt(0, 1, 0, 0, 1, 0); bt(0, 1, 1, 1, 1, 0); bt(0, 0, 0, 1, 1, 0);
        ctl(0, 0, 1, 1, 0, 0);

        // start+abort together in RUN; abort on a completing bit drops it.
        ctl(0, 1, 0, 0, 1, 0);
        ctl(0, 1, 1, 0, 0, 0);
        ctl(0, 1, 0, 0, 1, 0);
        bt(1, 1, 0, 0, 1, 0); bt(1, 1, 0, 0, 1, 0); bt(0, 1, 0, 0, 1, 0);
        add(0, 0, 8'h00, 4'd0, 0, 8'd0, 0, 1, 0, 1, 0, 8'd0, 0, 0, 0);
        ctl(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], $sformatf("vec%0d", i), 1'b1);
        end

        // Reset mid-run: outputs clear and config returns to pattern 0, len 1.
        h = '{default: '0};
        h.st = 1; h.eb = 1;                   apply(h, "mid_start", 1'b1);
        h = '{default: '0};
        h.d = 1; h.dv = 1; h.eb = 1;          apply(h, "mid_bit", 1'b1);
        h = '{default: '0};
        h.r = 1;                              apply(h, "mid_rst", 1'b1);
        h = '{default: '0};
        h.st = 1; h.eb = 1;                   apply(h, "rst_start", 1'b1);
        h = '{default: '0};
        h.d = 0; h.dv = 1; h.em = 1; h.ec = 1; h.eb = 1; apply(h, "rst_cfg_hit0", 1'b1);
        h = '{default: '0};
        h.d = 1; h.dv = 1; h.ec = 1; h.eb = 1;           apply(h, "rst_cfg_miss1", 1'b1);
        h = '{default: '0};
        h.d = 0; h.dv = 1; h.em = 1; h.ec = 2; h.eb = 1; apply(h, "rst_cfg_hit2", 1'b1);

        // Unlimited target: counter saturates at all-ones, match keeps pulsing.
        h = '{default: '0};
        h.d = 0; h.dv = 1;
        for (int k = 0; k < 258; k++) apply(h, "sat_fill", 1'b0);
        h.em = 1; h.ec = 8'hFF; h.eb = 1;
        apply(h, "sat_cnt", 1'b1);
        apply(h, "sat_hold", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
